// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative Booth multiplier.
// Unsigned support (mult_unsigned port) is enabled by defining MULT_UNSIGNED_EN.
package mult_pkg;

    localparam int MULT_WIDTH  = 32;
    localparam int MULT_ITER   = 32;
    localparam int MULT_ITER_U = 33;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/sub/none on the upper field of P,
// then an arithmetic right shift whose sign comes from the widened sum.
module booth_step #(
    parameter int WIDTH = 32,
    parameter int XW    = 32
) (
    input  logic [2*XW:0]    p,
    input  logic [WIDTH-1:0] m,
    input  logic             uns,
    output logic [2*XW:0]    p_next
);

    logic [XW:0] m_ext;
    logic [XW:0] upper;
    logic [XW:0] sum;

    always_comb begin
        // One extra bit beyond the field keeps the add from overflowing.
        m_ext = {{(XW + 1 - WIDTH){m[WIDTH-1] & ~uns}}, m};
        upper = {p[2*XW], p[2*XW:XW+1]};
        case (p[1:0])
            2'b01:   sum = upper + m_ext;
            2'b10:   sum = upper - m_ext;
            default: sum = upper;
        endcase
        p_next = {sum, p[XW:1]};
    end

endmodule

// File: rtl/booth_mult_unit.sv
// Iterative radix-2 Booth multiplier for MIPS mult (and multu when
// MULT_UNSIGNED_EN is defined); start/done handshake, product on hi/lo.
module booth_mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mult_in,
`ifdef MULT_UNSIGNED_EN
    input  logic             mult_unsigned,
`endif
    output logic             mult_out,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

`ifdef MULT_UNSIGNED_EN
    localparam int XW = WIDTH + 1;
`else
    localparam int XW = WIDTH;
`endif
    localparam int PW = 2 * XW + 1;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count, last_cnt;
    logic [PW-1:0]      p, p_step, p_load;
    logic [WIDTH-1:0]   m;
    logic               uns;
    logic               accept, finish;
    logic [2*WIDTH-1:0] product;

    booth_step #(.WIDTH(WIDTH), .XW(XW)) u_step (
        .p      (p),
        .m      (m),
        .uns    (uns),
        .p_next (p_step)
    );

`ifdef MULT_UNSIGNED_EN
    always_ff @(posedge clock) begin
        if (reset)
            uns <= 1'b0;
        else if (accept)
            uns <= mult_unsigned;
    end

    // Signed mode runs one iteration short of the widened field, leaving
    // the product one bit higher in P than in unsigned mode.
    always_comb begin
        p_load   = {{XW{1'b0}}, b[WIDTH-1] & ~mult_unsigned, b, 1'b0};
        last_cnt = uns ? CNT_W'(WIDTH) : CNT_W'(WIDTH - 1);
        product  = uns ? p_step[2*WIDTH:1] : p_step[2*WIDTH+1:2];
    end
`else
    assign uns = 1'b0;

    always_comb begin
        p_load   = {{XW{1'b0}}, b, 1'b0};
        last_cnt = CNT_W'(WIDTH - 1);
        product  = p_step[2*WIDTH:1];
    end
`endif

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        busy      = 1'b0;
        mult_out  = 1'b0;
        case (state)
            IDLE: begin
                if (mult_in) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count == last_cnt) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                mult_out  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            p     <= '0;
            m     <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                m     <= a;
                p     <= p_load;
                count <= '0;
            end else if (state == RUN) begin
                p     <= p_step;
                count <= count + CNT_W'(1);
            end
            // hi/lo keep the previous product until the new one is final.
            if (finish)
                {hi, lo} <= product;
        end
    end

endmodule

// File: tb/tb_booth_mult_unit.sv
// Randomized self-checking bench for booth_mult_unit against an
// integer-arithmetic product model; covers handshake, hold and reset cases.
module tb_booth_mult_unit;

    logic        clock   = 1'b0;
    logic        reset   = 1'b1;
    logic [31:0] a       = '0;
    logic [31:0] b       = '0;
    logic        mult_in = 1'b0;
    logic        mult_out;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MULT_UNSIGNED_EN
    logic        mult_unsigned = 1'b0;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_prod = '0;

    booth_mult_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock         (clock),
        .reset         (reset),
        .a             (a),
        .b             (b),
        .mult_in       (mult_in),
`ifdef MULT_UNSIGNED_EN
        .mult_unsigned (mult_unsigned),
`endif
        .mult_out      (mult_out),
        .busy          (busy),
        .hi            (hi),
        .lo            (lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input bit uns);
        longint sx, sy;
        if (uns) begin
            sx = longint'({32'b0, x});
            sy = longint'({32'b0, y});
        end else begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end
        return 64'(sx * sy);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called #1 after an edge with the unit idle; returns with it idle again.
    task automatic do_mult(input logic [31:0] x, input logic [31:0] y, input bit uns, input string tag);
        int          edges;
        int          lat;
        logic [63:0] exp;
        exp = model(x, y, uns);
        lat = uns ? 33 : 32;
        a = x;
        b = y;
        mult_in = 1'b1;
`ifdef MULT_UNSIGNED_EN
        mult_unsigned = uns;
`endif
        tick();
        mult_in = 1'b0;
        a = $urandom;
        b = $urandom;
        check({tag, ".busy"}, 64'(busy), 64'd1);
        edges = 0;
        while (mult_out !== 1'b1 && edges < 100) begin
            if (edges == 10)
                check({tag, ".hold"}, {hi, lo}, last_prod);
            tick();
            edges++;
        end
        check({tag, ".lat"}, 64'(edges), 64'(lat));
        check({tag, ".prod"}, {hi, lo}, exp);
        last_prod = exp;
        tick();
        check({tag, ".pulse"}, 64'({mult_out, busy}), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          pulses;
        int          pulse_at[$];
        bit          u;
        logic [31:0] x, y;

        tick();
        tick();
        check("rst.hilo", {hi, lo}, 64'd0);
        check("rst.ctl", 64'({mult_out, busy}), 64'd0);
        reset = 1'b0;
        tick();

        do_mult(32'd3, 32'd5, 1'b0, "t1");
        check("t1.const", {hi, lo}, 64'h0000_0000_0000_000F);
        do_mult(32'hFFFF_FFF9, 32'd6, 1'b0, "neg7x6");
        check("neg7x6.const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "m1xm1");
        check("m1xm1.const", {hi, lo}, 64'h0000_0000_0000_0001);
        do_mult(32'h8000_0000, 32'h8000_0000, 1'b0, "minxmin");
        check("minxmin.const", {hi, lo}, 64'h4000_0000_0000_0000);

        // Start request while running must be ignored.
        a = 32'd3; b = 32'd5; mult_in = 1'b1;
        tick();
        mult_in = 1'b0;
        pulses = 0;
        for (int e = 1; e <= 40; e++) begin
            if (e == 10) begin
                a = 32'd9; b = 32'd9; mult_in = 1'b1;
            end
            tick();
            if (e == 10) mult_in = 1'b0;
            if (mult_out) pulses++;
            if (e == 20) check("t3.hold", {hi, lo}, last_prod);
            if (e == 32) check("t3.lat", 64'(mult_out), 64'd1);
        end
        check("t3.pulses", 64'(pulses), 64'd1);
        check("t3.prod", {hi, lo}, 64'd15);
        last_prod = 64'd15;

        // Reset mid-operation abandons the multiply.
        a = 32'h1234; b = 32'h10; mult_in = 1'b1;
        tick();
        mult_in = 1'b0;
        for (int e = 1; e <= 14; e++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4.hilo", {hi, lo}, 64'd0);
        check("t4.ctl", 64'({mult_out, busy}), 64'd0);
        last_prod = '0;
        pulses = 0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (mult_out) pulses++;
        end
        check("t4.nopulse", 64'(pulses), 64'd0);
        do_mult(32'd2, 32'd2, 1'b0, "t4.new");

        // Held start: back-to-back multiplies.
        a = 32'd7; b = 32'hFFFF_FFFD; mult_in = 1'b1;
        for (int e = 0; e <= 100; e++) begin
            tick();
            if (mult_out) begin
                pulse_at.push_back(e);
                check("t5.prod", {hi, lo}, model(32'd7, 32'hFFFF_FFFD, 1'b0));
            end
        end
        mult_in = 1'b0;
        tick();
        tick();
        check("t5.count", 64'(pulse_at.size()), 64'd3);
        if (pulse_at.size() >= 2) begin
            check("t5.first", 64'(pulse_at[0]), 64'd32);
            check("t5.period", 64'(pulse_at[1] - pulse_at[0]), 64'd34);
        end
        last_prod = model(32'd7, 32'hFFFF_FFFD, 1'b0);

`ifdef MULT_UNSIGNED_EN
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "u.m1");
        check("u.m1.const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "s.m1");
        check("s.m1.const", {hi, lo}, 64'h0000_0000_0000_0001);
`endif

        for (int i = 0; i < 24; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 6 == 0) x = 32'h8000_0000;
            if (i % 6 == 1) y = 32'h7FFF_FFFF;
            if (i % 6 == 2) y = 32'd0;
            u = 1'b0;
`ifdef MULT_UNSIGNED_EN
            u = 1'($urandom_range(0, 1));
`endif
            do_mult(x, y, u, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
